output_display: RTL and testbench
=================================

Name: output_display

Overview:
- Output register and display driver for the 8-bit CPU, sitting directly downstream of the control unit.
- Captures the bus value on the control unit's output-register load strobe (loadDR) and converts it to decimal with a sequential shift-add-3 (double-dabble) engine.
- Drives a 4-digit multiplexed common-anode 7-segment display: optional minus sign, hundreds, tens, units.

Parameters:
- REFRESH_DIV, 16'd50000, clk cycles each digit is lit before advancing to the next; legal range 2..65535.
- BUS_W, 8, data bus width; only 8 is supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- bus  input  8  CPU data bus.
- loadDR  input  1  output-register load strobe from the control unit.
- signed_mode  input  1  1 = interpret the captured byte as two's complement; sampled together with bus on the load edge.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low, registered.
- an  output  4  digit anode enables, active-low one-hot, an[0] = units, registered.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (rst=1 at a rising edge):
  - seg=7'h7F, an=4'hF, busy=0.
  - Captured value, BCD registers and shown value all 0; unsigned display.
  - Refresh counter=0, digit index=0.
  - The first cycle after reset shows an=4'hE, seg=7'h40 ("0").
- Reset mid-conversion aborts the conversion; the display reverts to "0".
- Load:
  - On a rising edge with loadDR=1, capture bus and signed_mode.
  - Magnitude: if signed_mode=1 and bus[7]=1, magnitude = (~bus+1) as 8-bit unsigned, so 0x80 gives 128; otherwise magnitude = bus.
  - busy goes 1 on the following cycle.
- Conversion:
  - One shift per clock, 8 clocks total.
  - On the 8th clock the hundreds/tens/units/negative result is committed to the shown registers and busy returns to 0. busy is high for exactly 8 cycles.
  - The display keeps showing the previous value until the commit; there is no intermediate garbage.
- loadDR while busy: restart conversion with the new bus value (latest wins); busy stays high and 8 fresh cycles follow.
- loadDR held high for multiple cycles: each edge recaptures, so the conversion completes 8 cycles after the last high edge.
- Scanning:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - At terminal count, digit index advances 0→1→2→3→0 (wrap) and the counter returns to 0.
  - an and seg update in the same cycle as the index change (1-cycle registered path).
- Digit content:
  - idx0: units, always shown.
  - idx1: tens; blank if hundreds=0 and tens=0.
  - idx2: hundreds; blank if 0.
  - idx3: minus (seg=7'h3F) if negative, else blank (7'h7F).
- Segment codes, 0-9: 40,79,24,30,19,12,02,78,00,10 (hex).
- No overflow is possible: maximum magnitude is 255 unsigned / 128 signed.

Optional Feature:
- Macro OUTPUT_DISPLAY_HEX_EN.
- When defined:
  - Adds input port hex_mode (1 bit), sampled on the load edge.
  - If hex_mode=1: shown value is the raw byte as two hex digits on idx1/idx0, idx3/idx2 blank, no leading-zero blanking, signed_mode ignored.
  - Commit occurs the cycle after the load edge with busy=0 throughout.
  - Hex codes A-F: 08,03,46,21,06,0E.
- When undefined: no hex_mode port; decimal only.

Test Plan:
- Reset with REFRESH_DIV=4, no load → an cycles E,D,B,7 every 4 clocks; seg = 40,7F,7F,7F.
- bus=0xC8, signed_mode=0, loadDR 1 cycle → busy high exactly 8 cycles; then idx2/1/0 show 7'h79, 7'h24, 7'h40 ("200"); idx3 blank.
- bus=0xF6, signed_mode=1 → display "-10": idx3=7'h3F, idx2 blank, idx1=7'h79, idx0=7'h40.
- bus=0x80, signed_mode=1 → "-128": idx3=3F, idx2=79, idx1=24, idx0=00.
- Load 0x05, then load 0x07 three cycles later → busy stays high until 8 cycles after the second load; only "7" (7'h78) ever committed; "5" never shown.
- With OUTPUT_DISPLAY_HEX_EN, hex_mode=1, bus=0x3A → busy stays 0; next cycle idx1=7'h30, idx0=7'h08; idx3/idx2 blank.

Source files
------------

// File: rtl/output_display.sv
// output_display: latched bus value shown in decimal on a muxed 4-digit 7-seg display; OUTPUT_DISPLAY_HEX_EN adds hex_mode
module output_display #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter int          BUS_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] bus,
  input  logic             loadDR,
  input  logic             signed_mode,
`ifdef OUTPUT_DISPLAY_HEX_EN
  input  logic             hex_mode,
`endif
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             busy
);
  logic [19:0] sr_q, sr_d, adj;
  logic [2:0]  step_q, step_d;
  logic        busy_q, busy_d, neg_pend_q, neg_pend_d;
  logic [3:0]  hund_q, hund_d, tens_q, tens_d, units_q, units_d;
  logic        neg_q, neg_d, hex_q, hex_d;
  logic [15:0] ref_q, ref_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic [7:0]  mag;
  logic [3:0]  dig;
  logic        blank, term;
  function automatic logic [3:0] fix(input logic [3:0] d);
    return d >= 4'd5 ? d + 4'd3 : d;
  endfunction
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
  always_comb begin
    mag = (signed_mode && bus[7]) ? ~bus + 8'd1 : bus;
    // rotate rather than shift: the bit leaving the top is always 0 and lands in the spent binary field
    adj = {sr_q[19:16], fix(sr_q[15:12]), fix(sr_q[11:8]), sr_q[7:0]};
    sr_d = sr_q;
    step_d = step_q;
    busy_d = busy_q;
    neg_pend_d = neg_pend_q;
    hund_d = hund_q;
    tens_d = tens_q;
    units_d = units_q;
    neg_d = neg_q;
    hex_d = hex_q;
`ifdef OUTPUT_DISPLAY_HEX_EN
    if (loadDR && hex_mode) begin
      busy_d = 1'b0;
      hund_d = 4'd0;
      tens_d = bus[7:4];
      units_d = bus[3:0];
      neg_d = 1'b0;
      hex_d = 1'b1;
    end else
`endif
    if (loadDR) begin
      sr_d = {12'd0, mag};
      step_d = 3'd0;
      busy_d = 1'b1;
      neg_pend_d = signed_mode && bus[7];
    end else if (busy_q) begin
      sr_d = {adj[18:0], adj[19]};
      step_d = step_q + 3'd1;
      if (step_q == 3'd7) begin
        busy_d = 1'b0;
        hund_d = sr_d[19:16];
        tens_d = sr_d[15:12];
        units_d = sr_d[11:8];
        neg_d = neg_pend_q;
        hex_d = 1'b0;
      end
    end
    term = ref_q == REFRESH_DIV - 16'd1;
    ref_d = term ? 16'd0 : ref_q + 16'd1;
    idx_d = term ? idx_q + 2'd1 : idx_q;
    dig = idx_d == 2'd0 ? units_q : idx_d == 2'd1 ? tens_q : hund_q;
    blank = idx_d == 2'd3 ? 1'b1 :
            idx_d == 2'd2 ? (hex_q || hund_q == 4'd0) :
            idx_d == 2'd1 ? (!hex_q && hund_q == 4'd0 && tens_q == 4'd0) : 1'b0;
    seg_d = (idx_d == 2'd3 && neg_q) ? 7'h3F : blank ? 7'h7F : dec(dig);
    an_d = ~(4'b0001 << idx_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      neg_pend_q <= 1'b0;
      hund_q <= '0;
      tens_q <= '0;
      units_q <= '0;
      neg_q <= 1'b0;
      hex_q <= 1'b0;
      ref_q <= '0;
      idx_q <= '0;
      seg_q <= 7'h7F;
      an_q <= 4'hF;
    end else begin
      sr_q <= sr_d;
      step_q <= step_d;
      busy_q <= busy_d;
      neg_pend_q <= neg_pend_d;
      hund_q <= hund_d;
      tens_q <= tens_d;
      units_q <= units_d;
      neg_q <= neg_d;
      hex_q <= hex_d;
      ref_q <= ref_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q <= an_d;
    end
  end
  assign seg = seg_q;
  assign an = an_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_output_display.sv
// tb_output_display: random and directed loads checked against a decimal/hex display model
module tb_output_display;
  logic clk = 0, rst = 1, loadDR = 0, signed_mode = 0;
  logic [7:0] bus = 0;
`ifdef OUTPUT_DISPLAY_HEX_EN
  logic hex_mode = 0;
`endif
  logic [6:0] seg;
  logic [3:0] an;
  logic busy;
  int vectors = 0, miscompares = 0;
  logic [7:0] cur_val = 0;
  logic cur_sgn = 0, cur_hex = 0;
  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  output_display #(.REFRESH_DIV(16'd4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .loadDR(loadDR), .signed_mode(signed_mode),
`ifdef OUTPUT_DISPLAY_HEX_EN
    .hex_mode(hex_mode),
`endif
    .seg(seg), .an(an), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(int pos, logic [7:0] v, logic s, logic hx);
    int mag, h, t, u;
    bit neg;
    if (hx) return pos == 0 ? codes[v % 16] : pos == 1 ? codes[v / 16] : 7'h7F;
    neg = s && v[7];
    mag = neg ? 256 - int'(v) : int'(v);
    h = mag / 100; t = (mag / 10) % 10; u = mag % 10;
    case (pos)
      0: return codes[u];
      1: return (h == 0 && t == 0) ? 7'h7F : codes[t];
      2: return h == 0 ? 7'h7F : codes[h];
      default: return neg ? 7'h3F : 7'h7F;
    endcase
  endfunction

  function automatic int pos_of(logic [3:0] a);
    return a == 4'hE ? 0 : a == 4'hD ? 1 : a == 4'hB ? 2 : a == 4'h7 ? 3 : -1;
  endfunction

  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_seg_now(string tag, logic [7:0] v, logic s, logic hx);
    int p;
    p = pos_of(an);
    if (p < 0) check({tag, "_an"}, {4'h0, an}, 8'h0E);
    else check(tag, {1'b0, seg}, {1'b0, exp_seg(p, v, s, hx)});
  endtask

  task automatic check_display(string tag, logic [7:0] v, logic s, logic hx);
    for (int i = 0; i < 16; i++) begin
      check_seg_now(tag, v, s, hx);
      tick;
    end
  endtask

  task automatic finish_conv(string tag, logic [7:0] v, logic s);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, {7'h0, busy}, 8'h01);
      check_seg_now({tag, "_hold"}, cur_val, cur_sgn, cur_hex);
      tick;
    end
    check({tag, "_done"}, {7'h0, busy}, 8'h00);
    cur_val = v; cur_sgn = s; cur_hex = 0;
    tick;
    check_display(tag, v, s, 0);
  endtask

  task automatic do_load(string tag, logic [7:0] v, logic s, logic hx);
    bus = v; signed_mode = s; loadDR = 1;
`ifdef OUTPUT_DISPLAY_HEX_EN
    hex_mode = hx;
`endif
    tick;
    loadDR = 0;
    if (hx) begin
      check({tag, "_busy"}, {7'h0, busy}, 8'h00);
      cur_val = v; cur_sgn = s; cur_hex = 1;
      tick;
      check_display(tag, v, s, 1);
    end else finish_conv(tag, v, s);
  endtask

  initial begin
    tick;
    tick;
    check("rst_seg", {1'b0, seg}, 8'h7F);
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_busy", {7'h0, busy}, 8'h00);
    rst = 0;
    for (int j = 1; j <= 16; j++) begin
      tick;
      check("scan_an", {4'h0, an}, {4'h0, ~(4'b0001 << ((j / 4) % 4))});
      check("scan_seg", {1'b0, seg}, ((j / 4) % 4) == 0 ? 8'h40 : 8'h7F);
    end
    do_load("u200", 8'hC8, 0, 0);
    do_load("m10", 8'hF6, 1, 0);
    do_load("m128", 8'h80, 1, 0);
    do_load("u255", 8'hFF, 0, 0);
    do_load("m1", 8'hFF, 1, 0);
    do_load("zero", 8'h00, 1, 0);
    do_load("p127", 8'h7F, 1, 0);
    // restart: 0x05 loaded, then 0x07 three cycles later; 5 must never appear
    bus = 8'h05; signed_mode = 0; loadDR = 1;
    tick;
    loadDR = 0;
    for (int i = 0; i < 3; i++) begin
      check("rs_busy", {7'h0, busy}, 8'h01);
      check_seg_now("rs_hold", cur_val, cur_sgn, cur_hex);
      if (i < 2) tick;
    end
    bus = 8'h07; loadDR = 1;
    tick;
    loadDR = 0;
    finish_conv("restart", 8'h07, 0);
    bus = 8'h11; loadDR = 1;
    tick;
    bus = 8'h22;
    tick;
    bus = 8'h2A;
    tick;
    loadDR = 0;
    finish_conv("held", 8'h2A, 0);
    for (int k = 0; k < 20; k++)
      do_load("rand", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
`ifdef OUTPUT_DISPLAY_HEX_EN
    do_load("hex3a", 8'h3A, 1, 1);
    do_load("hexf0", 8'hF0, 0, 1);
    do_load("dec_after_hex", 8'h09, 0, 0);
`endif
    bus = 8'h99; signed_mode = 0; loadDR = 1;
    tick;
    loadDR = 0;
    tick;
    tick;
    rst = 1;
    tick;
    rst = 0;
    check("mrst_busy", {7'h0, busy}, 8'h00);
    check("mrst_an", {4'h0, an}, 8'h0F);
    cur_val = 0; cur_sgn = 0; cur_hex = 0;
    tick;
    check_display("mrst", 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) begin
      check("mrst_idle", {7'h0, busy}, 8'h00);
      tick;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
